// File: rtl/bus_frame_receiver.sv
// bus_frame_receiver: deserialises one bus frame at a time, recomputes CRC-4, filters on address
// and presents good payloads on a one-entry valid/ready register. RX_STATS_EN adds frame counters.
module bus_frame_receiver #(
  parameter logic [3:0] MY_ADDR  = 4'd1,
  parameter logic [3:0] CRC_POLY = 4'b0011,
  parameter logic [3:0] CRC_INIT = 4'b0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        bus_in,
  input  logic        rx_ready,
  output logic        rx_valid,
  output logic [63:0] rx_data,
  output logic [3:0]  rx_src,
  output logic [1:0]  rx_mod,
  output logic        crc_err,
  output logic        overflow,
  output logic        busy
`ifdef RX_STATS_EN
  ,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_err
`endif
);

  // state  | meaning
  // S_IDLE | waiting for a start bit (bus_in==1)
  // S_HDR  | shifting src, dst, mod (10 bits)
  // S_PAY  | shifting payload (8/16/32/64 bits, from mod)
  // S_CRC  | shifting received CRC (4 bits)
  // S_CHK  | one cycle: address/CRC decision, bus_in ignored
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
    S_CRC  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [6:0]  cnt, cnt_nxt;
  logic [9:0]  hdr_sr;
  logic [63:0] pay_sr;
  logic [3:0]  crc_calc;
  logic [3:0]  crc_rcv;

  logic [3:0]  hdr_src;
  logic [3:0]  hdr_dst;
  logic [1:0]  hdr_mod;
  logic [1:0]  mod_in;
  logic        addr_match;
  logic        crc_ok;
  logic        deliver;
  logic        load;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'b0000);
  endfunction

  function automatic logic [6:0] pay_last(input logic [1:0] m);
    case (m)
      2'b00:   return 7'd7;
      2'b01:   return 7'd15;
      2'b10:   return 7'd31;
      default: return 7'd63;
    endcase
  endfunction

  assign hdr_src = hdr_sr[9:6];
  assign hdr_dst = hdr_sr[5:2];
  assign hdr_mod = hdr_sr[1:0];
  // mod is complete only together with the bit being sampled on the last header edge
  assign mod_in  = {hdr_sr[0], bus_in};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (bus_in) begin
          state_nxt = S_HDR;
          cnt_nxt   = 7'd9;
        end
      end
      S_HDR: begin
        if (cnt == 7'd0) begin
          state_nxt = S_PAY;
          cnt_nxt   = pay_last(mod_in);
        end else begin
          cnt_nxt = cnt - 7'd1;
        end
      end
      S_PAY: begin
        if (cnt == 7'd0) begin
          state_nxt = S_CRC;
          cnt_nxt   = 7'd3;
        end else begin
          cnt_nxt = cnt - 7'd1;
        end
      end
      S_CRC: begin
        if (cnt == 7'd0) begin
          state_nxt = S_CHK;
          cnt_nxt   = 7'd0;
        end else begin
          cnt_nxt = cnt - 7'd1;
        end
      end
      S_CHK: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 7'd0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hdr_sr   <= '0;
      pay_sr   <= '0;
      crc_calc <= '0;
      crc_rcv  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // clearing the payload here keeps short payloads right-aligned with zero upper bits
          if (bus_in) begin
            hdr_sr   <= '0;
            pay_sr   <= '0;
            crc_calc <= CRC_INIT;
            crc_rcv  <= '0;
          end
        end
        S_HDR: begin
          hdr_sr   <= {hdr_sr[8:0], bus_in};
          crc_calc <= crc_step(crc_calc, bus_in);
        end
        S_PAY: begin
          pay_sr   <= {pay_sr[62:0], bus_in};
          crc_calc <= crc_step(crc_calc, bus_in);
        end
        S_CRC: begin
          crc_rcv <= {crc_rcv[2:0], bus_in};
        end
        default: begin
        end
      endcase
    end
  end

  assign addr_match = (hdr_dst == MY_ADDR) || (hdr_dst == 4'hF);
  assign crc_ok     = (crc_calc == crc_rcv);
  assign deliver    = (state == S_CHK) && addr_match && crc_ok;
  assign load       = deliver && (!rx_valid || rx_ready);
  assign crc_err    = (state == S_CHK) && addr_match && !crc_ok;
  assign overflow   = deliver && rx_valid && !rx_ready;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_src   <= '0;
      rx_mod   <= '0;
    end else if (load) begin
      rx_valid <= 1'b1;
      rx_data  <= pay_sr;
      rx_src   <= hdr_src;
      rx_mod   <= hdr_mod;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef RX_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_ok  <= '0;
      stat_err <= '0;
    end else begin
      if (load && (stat_ok != 16'hFFFF)) begin
        stat_ok <= stat_ok + 16'd1;
      end
      if (crc_err && (stat_err != 16'hFFFF)) begin
        stat_err <= stat_err + 16'd1;
      end
    end
  end
`endif

endmodule
